filter_multi: RTL and testbench
===============================

Name: filter_multi

Overview:
- Parametrised successor to the single-width filter block; sits between a system-bus position input and a capture/PCAP-style consumer.
- While enabled, the block continuously processes a signed sample stream.
- On each trigger it emits one result, selected by the latched mode:
  - difference since the last trigger,
  - mean since the last trigger (sequential divider),
  - peak maximum, or
  - peak minimum.
- Sticky error flags report accumulator/counter overflow and re-triggering while the divider is busy.

Parameters:
- DW, 32, sample and result width (signed).
- ACCW, 64, accumulator width (signed); must be ≥ DW+1. Also sets the divider iteration count.
- CNTW, 32, sample-counter width (unsigned).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- mode_i  in  2  0=difference, 1=average, 2=max, 3=min; latched only on the enable rising edge.
- enable_i  in  1  run gate; its rising edge starts a new acquisition.
- trig_i  in  1  result request; sampled only while enable_i=1.
- inp_i  in  DW  signed sample, taken every clock while enabled.
- out_o  out  DW  signed result, held until the next result.
- ready_o  out  1  one-cycle strobe marking out_o valid.
- busy_o  out  1  high while the divider is running.
- err_o  out  2  [0] accumulator/counter overflow (sticky); [1] trigger while busy (sticky).

Behaviour:
- Reset: all outputs 0. Reset also clears the accumulator, count, reference and extreme registers, and the latched mode. Reset during a divide aborts it; no ready_o is produced.
- Enable rising edge (enable_i=1, previous cycle 0), cycle E:
  - latch mode_i; clear err_o;
  - initialise ref, max and min to inp_i;
  - acc <= sign-extended inp_i; count <= 1;
  - any trig_i in cycle E is ignored.
- Each later cycle with enable_i=1 and no trigger:
  - acc <= acc + inp_i;
  - count <= count + 1;
  - max/min updated with inp_i.
- Overflow:
  - Signed overflow of acc: acc saturates at the ACCW limit and err_o[0] is set.
  - count reaching 2^CNTW-1: count saturates and err_o[0] is set.
- Trigger handling, trigger cycle T (T≠E, enable_i=1); the current inp_i is always included:
  - Mode 0 (difference):
    - out_o <= inp_i - ref, DW-bit wrap;
    - ref <= inp_i;
    - ready_o=1 at T+1.
  - Mode 1 (average):
    - snapshot S = acc + inp_i and N = count + 1;
    - acc <= 0; count <= 0; busy_o <= 1 from T+1;
    - restoring divider, one bit per cycle over ACCW iterations, dividing |S| by N;
    - result sign is applied after the divide and truncated to DW bits;
    - out_o valid and ready_o=1 at exactly T+ACCW+2; busy_o falls in the same cycle.
  - Mode 2 (max) / mode 3 (min):
    - out_o <= extreme including inp_i;
    - the extreme restarts from the next sample;
    - ready_o=1 at T+1.
- Trigger while busy_o=1: the trigger is ignored and err_o[1] is set. The running divide is unaffected.
- Accumulation is unaffected by busy_o: new samples continue to accumulate into the cleared acc.
- enable_i falling:
  - accumulation and trigger acceptance stop;
  - any divide in progress completes and emits ready_o;
  - out_o and err_o are held until the next enable rising edge.
- mode_i changes while enabled have no effect.
- Registers, including err_o, hold their values while enable_i=0.

Optional Feature:
- Macro: FILTER_ROUND_EN.
- Defined: the average divides |S| + floor(N/2), giving round-half-away-from-zero. Latency is unchanged.
- Undefined: truncation toward zero.
- Modes 0, 2 and 3 are identical in both builds.

Test Plan:
- Difference (mode 0):
  - Stimulus: enable with inp=100, ramp +1 per cycle, trig at sample 10.
  - Response: out_o=10, ready_o one cycle after trig.
  - Stimulus: second trig 5 cycles later.
  - Response: out_o=5.
- Average (mode 1):
  - Stimulus: enable, inp sequence 1,2,3,4 with trig on the sample of 4.
  - Response: out_o=2 (3 with FILTER_ROUND_EN), ready_o exactly 66 cycles after trig, busy_o high for cycles T+1..T+65.
  - Stimulus: inp sequence -1,-2 with trig on the sample of -2.
  - Response: out_o=-1 (-2 with FILTER_ROUND_EN).
- Max (mode 2):
  - Stimulus: inp sequence 5,-3,9,2 with trig on 2.
  - Response: out_o=9.
- Min (mode 3):
  - Stimulus: next window 7,4, trig.
  - Response: out_o=4 (no carry-over from the previous window).
- Busy retrigger (mode 1):
  - Stimulus: second trig 10 cycles after the first.
  - Response: err_o[1]=1, exactly one ready_o, at first trig+66. Next enable rising edge clears err_o.
- Overflow (ACCW=DW+1=33):
  - Stimulus: feed 0x7FFFFFFF for 3 cycles.
  - Response: err_o[0]=1 and the accumulator saturates.
- Reset mid-divide:
  - Stimulus: reset_i pulse at T+20.
  - Response: no ready_o; out_o=0, busy_o=0, err_o=0 the following cycle.
- Enable-edge trigger:
  - Stimulus: trig in the same cycle as the enable rising edge.
  - Response: no ready_o.

Source files
------------

// File: rtl/filter_multi.sv
// Windowed signed-sample filter: on each trigger emits difference, mean, max or min of the window.
// Mean uses a restoring divider; defining FILTER_ROUND_EN rounds it half away from zero.
module filter_multi #(
    parameter int DW   = 32,
    parameter int ACCW = 64,
    parameter int CNTW = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [1:0]           mode_i,
    input  logic                 enable_i,
    input  logic                 trig_i,
    input  logic signed [DW-1:0] inp_i,
    output logic signed [DW-1:0] out_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [1:0]           err_o
);
    localparam int ITW = $clog2(ACCW + 1);
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic signed [DW-1:0]   DAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   DAT_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CNTW-1:0]        CNT_MAX = '1;

    logic                   en_q, en_d;
    logic [1:0]             mode_q, mode_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic signed [DW-1:0]   ref_q, ref_d, max_q, max_d, min_q, min_d;
    logic signed [DW-1:0]   out_q, out_d;
    logic                   ready_q, ready_d, busy_q, busy_d;
    logic [1:0]             err_q, err_d;
    logic [CNTW-1:0]        rem_q, rem_d, den_q, den_d;
    logic [ACCW-1:0]        quo_q, quo_d;
    logic [ITW-1:0]         it_q, it_d;
    logic                   neg_q, neg_d;

    logic signed [ACCW-1:0] inp_ext, acc_sum;
    logic [ACCW:0]          acc_raw;
    logic                   acc_ovf, cnt_sat, take;
    logic [CNTW-1:0]        cnt_inc;
    logic signed [DW-1:0]   max_nxt, min_nxt;
    logic [ACCW-1:0]        acc_mag, dvd;
    logic [CNTW:0]          rem_sh;

    always_comb begin
        inp_ext = {{(ACCW-DW){inp_i[DW-1]}}, inp_i};
        acc_raw = {acc_q[ACCW-1], acc_q} + {inp_ext[ACCW-1], inp_ext};
        // carry-out disagreeing with the sign bit means signed overflow: clamp
        acc_ovf = acc_raw[ACCW] ^ acc_raw[ACCW-1];
        acc_sum = acc_ovf ? (acc_raw[ACCW] ? ACC_MIN : ACC_MAX) : acc_raw[ACCW-1:0];
        cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNTW'(1);
        cnt_sat = (cnt_inc == CNT_MAX);
        max_nxt = (inp_i > max_q) ? inp_i : max_q;
        min_nxt = (inp_i < min_q) ? inp_i : min_q;
        acc_mag = acc_sum[ACCW-1] ? $unsigned(-acc_sum) : $unsigned(acc_sum);
`ifdef FILTER_ROUND_EN
        dvd = acc_mag + ACCW'(cnt_inc >> 1);
`else
        dvd = acc_mag;
`endif
        rem_sh = {rem_q, quo_q[ACCW-1]};
    end

    always_comb begin
        en_d    = enable_i;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        max_d   = max_q;
        min_d   = min_q;
        out_d   = out_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        it_d    = it_q;
        neg_d   = neg_q;
        take    = 1'b0;

        // the divider keeps running regardless of enable so a started mean always completes
        if (busy_q) begin
            if (it_q != ITW'(ACCW)) begin
                if (rem_sh >= {1'b0, den_q}) begin
                    rem_d = CNTW'(rem_sh - {1'b0, den_q});
                    quo_d = {quo_q[ACCW-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[CNTW-1:0];
                    quo_d = {quo_q[ACCW-2:0], 1'b0};
                end
                it_d = it_q + ITW'(1);
            end else begin
                out_d   = DW'(neg_q ? -quo_q : quo_q);
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        end

        if (enable_i && !en_q) begin
            mode_d = mode_i;
            err_d  = 2'b00;
            ref_d  = inp_i;
            max_d  = inp_i;
            min_d  = inp_i;
            acc_d  = inp_ext;
            cnt_d  = CNTW'(1);
        end else if (enable_i) begin
            take  = trig_i && !busy_q;
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            max_d = max_nxt;
            min_d = min_nxt;
            if (acc_ovf || cnt_sat) err_d[0] = 1'b1;
            if (trig_i && busy_q)   err_d[1] = 1'b1;
            if (take) begin
                case (mode_q)
                    2'd0: begin
                        out_d   = inp_i - ref_q;
                        ref_d   = inp_i;
                        ready_d = 1'b1;
                    end
                    2'd1: begin
                        acc_d  = '0;
                        cnt_d  = '0;
                        busy_d = 1'b1;
                        rem_d  = '0;
                        quo_d  = dvd;
                        den_d  = cnt_inc;
                        it_d   = '0;
                        neg_d  = acc_sum[ACCW-1];
                    end
                    default: begin
                        out_d   = mode_q[0] ? min_nxt : max_nxt;
                        ready_d = 1'b1;
                        // identity values so the next sample starts a fresh extreme
                        max_d   = DAT_MIN;
                        min_d   = DAT_MAX;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q    <= 1'b0;
            mode_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ref_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            it_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            max_q   <= max_d;
            min_q   <= min_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            it_q    <= it_d;
            neg_q   <= neg_d;
        end
    end

    assign out_o   = out_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_filter_multi.sv
// Scoreboard bench for filter_multi: window-level reference model, directed and random windows.
module tb_filter_multi;
    localparam int DW = 32, ACCW = 64, CNTW = 32, SACCW = DW + 1;
    typedef struct { int val; int at; } exp_t;

    logic clk = 1'b0, rst, en, en_s, trig;
    logic [1:0] mode;
    logic signed [DW-1:0] inp, out_m, out_s;
    logic rdy_m, rdy_s, busy_m, busy_s;
    logic [1:0] err_m, err_s;

    int vectors = 0, miscompares = 0, cyc = 0;
    exp_t q_m[$], q_s[$];
    bit m_prev = 0, m_err1 = 0;
    int m_mode = 0, m_ref = 0, L = -1000;
    int win[$], ext[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    filter_multi #(.DW(DW), .ACCW(ACCW), .CNTW(CNTW)) dut (
        .clk_i(clk), .reset_i(rst), .mode_i(mode), .enable_i(en), .trig_i(trig), .inp_i(inp),
        .out_o(out_m), .ready_o(rdy_m), .busy_o(busy_m), .err_o(err_m));

    filter_multi #(.DW(DW), .ACCW(SACCW), .CNTW(CNTW)) dut_s (
        .clk_i(clk), .reset_i(rst), .mode_i(mode), .enable_i(en_s), .trig_i(trig), .inp_i(inp),
        .out_o(out_s), .ready_o(rdy_s), .busy_o(busy_s), .err_o(err_s));

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // mean over the window, sign applied to the magnitude quotient
    function automatic int avg(input int w[$]);
        longint s = 0, n, m, qv;
        foreach (w[i]) s += w[i];
        n = w.size();
        m = (s < 0) ? -s : s;
`ifdef FILTER_ROUND_EN
        m += n / 2;
`endif
        qv = m / n;
        return int'((s < 0) ? -qv : qv);
    endfunction

    function automatic int extreme(input int w[$], input bit want_max);
        int r = w[0];
        foreach (w[i]) if (want_max ? (w[i] > r) : (w[i] < r)) r = w[i];
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rdy_m) begin
            if (q_m.size() == 0) check("main_unexpected_ready", rdy_m, 0);
            else begin
                e = q_m.pop_front();
                check("main_ready_cycle", cyc, e.at);
                check("main_result", out_m, e.val);
            end
        end else if (q_m.size() != 0 && q_m[0].at <= cyc) begin
            check("main_missing_ready", rdy_m, 1);
            void'(q_m.pop_front());
        end
        if (rdy_s) begin
            if (q_s.size() == 0) check("sat_unexpected_ready", rdy_s, 0);
            else begin
                e = q_s.pop_front();
                check("sat_ready_cycle", cyc, e.at);
                check("sat_result", out_s, e.val);
            end
        end else if (q_s.size() != 0 && q_s[0].at <= cyc) begin
            check("sat_missing_ready", rdy_s, 1);
            void'(q_s.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e_, input bit t_, input int md, input int x);
        int edge_ = cyc + 1;
        bit b = (cyc >= L) && (cyc <= L + ACCW);
        en = e_; trig = t_; mode = 2'(md); inp = x; en_s = 1'b0; rst = 1'b0;
        if (e_ && !m_prev) begin
            m_mode = md; m_ref = x; win = {x}; ext = {x}; m_err1 = 0;
        end else if (e_) begin
            win.push_back(x);
            ext.push_back(x);
            if (t_ && b) m_err1 = 1;
            else if (t_) begin
                case (m_mode)
                    0: begin q_m.push_back('{x - m_ref, edge_}); m_ref = x; end
                    1: begin q_m.push_back('{avg(win), edge_ + ACCW + 1}); win.delete(); L = edge_; end
                    default: begin q_m.push_back('{extreme(ext, m_mode == 2), edge_}); ext.delete(); end
                endcase
            end
        end
        m_prev = e_;
        step();
        check("busy", busy_m, (cyc >= L) && (cyc <= L + ACCW));
        check("err_retrig", err_m[1], m_err1);
        check("err_ovf", err_m[0], 0);
    endtask

    task automatic reset_pulse();
        int edge_ = cyc + 1;
        rst = 1'b1; en = 1'b0; en_s = 1'b0; trig = 1'b0;
        for (int i = q_m.size() - 1; i >= 0; i--) if (q_m[i].at >= edge_) q_m.delete(i);
        for (int i = q_s.size() - 1; i >= 0; i--) if (q_s[i].at >= edge_) q_s.delete(i);
        m_prev = 0; m_err1 = 0; L = -1000;
        step();
        check("rst_out", out_m, 0);
        check("rst_ready", rdy_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_err", err_m, 0);
        check("rst_out_s", out_s, 0);
        check("rst_busy_s", busy_s, 0);
        check("rst_err_s", err_s, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en_s = 1'b0; trig = 1'b0; mode = 2'd0; inp = '0;
        step();
        reset_pulse();

        // difference: ramp from 100, trigger at sample 10 then 5 later
        drive(1, 0, 0, 100);
        for (int i = 1; i < 10; i++) drive(1, 0, 0, 100 + i);
        drive(1, 1, 0, 110);
        for (int i = 1; i < 5; i++) drive(1, 0, 0, 110 + i);
        drive(1, 1, 0, 115);
        drive(0, 0, 0, 0);

        // mean of 1..4, divide completes with enable low
        drive(1, 0, 1, 1); drive(1, 0, 1, 2); drive(1, 0, 1, 3); drive(1, 1, 1, 4);
        repeat (ACCW + 4) drive(0, 0, 1, 0);
        drive(1, 0, 1, -1); drive(1, 1, 1, -2);
        repeat (ACCW + 4) drive(0, 0, 1, 0);

        // retrigger while busy
        drive(1, 0, 1, 10); drive(1, 1, 1, 20);
        repeat (9) drive(1, 0, 1, 5);
        drive(1, 1, 1, 7);
        repeat (ACCW + 4) drive(1, 0, 1, 3);
        drive(0, 0, 0, 0);

        // max then a fresh min window
        drive(1, 0, 2, 5); drive(1, 0, 2, -3); drive(1, 0, 2, 9); drive(1, 1, 2, 2);
        drive(1, 0, 2, 1); drive(1, 0, 2, 0); drive(1, 1, 2, -4);
        drive(0, 0, 0, 0);
        drive(1, 0, 3, 7); drive(1, 1, 3, 4);
        drive(0, 0, 0, 0);

        // trigger coincident with enable edge
        drive(1, 1, 0, 50); drive(1, 0, 0, 51); drive(0, 0, 0, 0);

        // reset in the middle of a divide
        drive(1, 0, 1, 100); drive(1, 1, 1, 300);
        repeat (19) drive(1, 0, 1, 1);
        reset_pulse();
        repeat (ACCW + 4) drive(0, 0, 1, 0);

        // saturation on the narrow-accumulator instance
        en = 1'b0; en_s = 1'b1; mode = 2'd1; inp = 32'sh7FFFFFFF; trig = 1'b0;
        step(); step();
        check("sat_err_before", err_s[0], 0);
        trig = 1'b1;
        step();
        check("sat_err_after", err_s[0], 1);
        check("sat_busy", busy_s, 1);
        q_s.push_back('{32'sh55555555, cyc + SACCW + 1});
        trig = 1'b0; en_s = 1'b0;
        repeat (SACCW + 5) step();
        check("sat_err_held", err_s[0], 1);

        // random windows, random modes and triggers
        for (int w = 0; w < 30; w++) begin
            int md = $urandom_range(3);
            int len = $urandom_range(20, 3);
            drive(0, 0, md, 0);
            drive(1, $urandom_range(1), md, $urandom);
            for (int i = 0; i < len; i++) drive(1, $urandom_range(4) == 0, $urandom_range(3), $urandom);
            if ($urandom_range(1) == 1) repeat (ACCW + 2) drive(0, $urandom_range(1), md, $urandom);
        end
        repeat (ACCW + 4) drive(0, 0, 0, 0);
        check("main_pending", q_m.size(), 0);
        check("sat_pending", q_s.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
